// File: rtl/hgcal_fc_aligned_decoder.sv
// hgcal_fc_aligned_decoder
//   Recovers the 8-bit word boundary of the serial fast-control stream by hunting on IDLE words
//   with automatic bitslip. Lock and unlock use hysteresis. Commands decode into pulses one clk40
//   period (8 clk320 cycles) wide. The block tracks BX and orbit and flags a mis-timed OrbitSync.
//
// Optional feature: define FC_ERRCNT_EN to add err_count, a saturating count of invalid words
// seen while locked plus orbit_err events. OCR and reset clear it.
//
// Ports
//   clk320                      in   320 MHz clock, the only clock
//   n_rstExt                    in   asynchronous active-low reset
//   command_rx                  in   serial fast-control bit, MSB of each word first
//   clk40_out                   out  recovered 40 MHz clock
//   locked                      out  word alignment locked
//   L1A_Full .. ReSync          out  decoded command pulses, 8 cycles wide
//   bx_count [BX_W]             out  current BX
//   orbit_count [ORB_W]         out  orbits since last OCR
//   orbit_err                   out  1-cycle pulse, OrbitSync at the wrong BX
//   err_count [16]              out  (FC_ERRCNT_EN only) error counter
module hgcal_fc_aligned_decoder #(
  parameter int unsigned LOCK_GOOD  = 16,
  parameter int unsigned UNLOCK_BAD = 4,
  parameter int unsigned ORBIT_LEN  = 3564,
  parameter int unsigned BX_W       = 12,
  parameter int unsigned ORB_W      = 16,
  parameter logic [7:0]  IDLE_WORD  = 8'hAC,
  parameter logic [7:0]  CMD_L1A    = 8'h4B,
  parameter logic [7:0]  CMD_ORBIT  = 8'h2D,
  parameter logic [7:0]  CMD_OCR    = 8'h33,
  parameter logic [7:0]  CMD_CALREQ = 8'h55,
  parameter logic [7:0]  CMD_CALL1A = 8'h66,
  parameter logic [7:0]  CMD_RESYNC = 8'h99
) (
  input  logic             clk320,
  input  logic             n_rstExt,
  input  logic             command_rx,
  output logic             clk40_out,
  output logic             locked,
  output logic             L1A_Full,
  output logic             OrbitSync,
  output logic             OrbitCountReset_OrbitSync,
  output logic             CalibrationReq,
  output logic             CalibrationL1A,
  output logic             ReSync,
  output logic [BX_W-1:0]  bx_count,
  output logic [ORB_W-1:0] orbit_count,
`ifdef FC_ERRCNT_EN
  output logic [15:0]      err_count,
`endif
  output logic             orbit_err
);

  localparam int unsigned GoodW = $clog2(LOCK_GOOD + 1);
  localparam int unsigned BadW  = $clog2(UNLOCK_BAD + 1);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [6:0]       sr_q;
  logic [GoodW-1:0] good_q, good_d;
  logic [BadW-1:0]  bad_q, bad_d;
  logic [5:0]       pulse_q, pulse_d;
  logic             clk40_q, clk40_d;
  logic [BX_W-1:0]  bx_q, bx_d;
  logic [ORB_W-1:0] orbit_q, orbit_d;
  logic             bx_valid_q, bx_valid_d;
  logic             orbit_err_q, orbit_err_d;

  logic       boundary, is_idle, is_valid, good_hit, bad_hit, bx_end;
  logic [7:0] word;
  logic [5:0] cmd_hit;

  // Word completes on the cycle its last bit arrives, so the live input is the LSB.
  assign word     = {sr_q, command_rx};
  assign boundary = (phase_q == 3'd7);
  assign is_idle  = (word == IDLE_WORD);
  // Bit order matches pulse_q: {ReSync, CalL1A, CalReq, OCR, OrbitSync, L1A}
  assign cmd_hit  = {word == CMD_RESYNC, word == CMD_CALL1A, word == CMD_CALREQ,
                     word == CMD_OCR,    word == CMD_ORBIT,  word == CMD_L1A};
  assign is_valid = is_idle | (|cmd_hit);
  assign good_hit = ((good_q + 1'b1) == GoodW'(LOCK_GOOD));
  assign bad_hit  = ((bad_q + 1'b1) == BadW'(UNLOCK_BAD));
  assign bx_end   = (bx_q == BX_W'(ORBIT_LEN - 1));

  // State register
  always_ff @(posedge clk320 or negedge n_rstExt) begin
    if (!n_rstExt) begin
      state_q     <= StHunt;
      phase_q     <= '0;
      sr_q        <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      pulse_q     <= '0;
      clk40_q     <= 1'b0;
      bx_q        <= '0;
      orbit_q     <= '0;
      bx_valid_q  <= 1'b0;
      orbit_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sr_q        <= {sr_q[5:0], command_rx};
      good_q      <= good_d;
      bad_q       <= bad_d;
      pulse_q     <= pulse_d;
      clk40_q     <= clk40_d;
      bx_q        <= bx_d;
      orbit_q     <= orbit_d;
      bx_valid_q  <= bx_valid_d;
      orbit_err_q <= orbit_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (boundary) begin
      unique case (state_q)
        StHunt:   if (is_idle && good_hit) state_d = StLocked;
        StLocked: if (!is_valid && bad_hit) state_d = StHunt;
        default:  state_d = StHunt;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    phase_d     = phase_q + 3'd1;
    clk40_d     = (phase_q < 3'd4);
    good_d      = good_q;
    bad_d       = bad_q;
    pulse_d     = pulse_q;
    bx_d        = bx_q;
    orbit_d     = orbit_q;
    bx_valid_d  = bx_valid_q;
    orbit_err_d = 1'b0;
    if (boundary) begin
      pulse_d = '0;
      unique case (state_q)
        StHunt: begin
          if (is_idle) begin
            good_d = good_q + 1'b1;
            if (good_hit) bad_d = '0;
          end else if (!is_valid) begin
            good_d  = '0;
            // Bitslip: repeat phase 7 so the next cycle is a boundary one bit later
            phase_d = 3'd7;
          end
        end
        StLocked: begin
          if (cmd_hit[2]) begin
            bx_d       = '0;
            orbit_d    = '0;
            bx_valid_d = 1'b1;
          end else begin
            bx_d = bx_end ? '0 : bx_q + 1'b1;
            if (bx_end) orbit_d = orbit_q + 1'b1;
            if (cmd_hit[1]) begin
              orbit_err_d = bx_valid_q & ~bx_end;
              bx_d        = '0;
              bx_valid_d  = 1'b1;
            end
          end
          if (is_valid) begin
            bad_d   = '0;
            pulse_d = cmd_hit;
          end else begin
            bad_d = bad_q + 1'b1;
            if (bad_hit) begin
              good_d     = '0;
              bx_valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FC_ERRCNT_EN
  logic [15:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (boundary && state_q == StLocked) begin
      if (cmd_hit[2]) begin
        err_d = '0;
      end else if ((!is_valid || orbit_err_d) && err_q != 16'hFFFF) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk320 or negedge n_rstExt) begin
    if (!n_rstExt) err_q <= '0;
    else           err_q <= err_d;
  end

  assign err_count = err_q;
`endif

  assign clk40_out                 = clk40_q;
  assign locked                    = (state_q == StLocked);
  assign L1A_Full                  = pulse_q[0];
  assign OrbitSync                 = pulse_q[1];
  assign OrbitCountReset_OrbitSync = pulse_q[2];
  assign CalibrationReq            = pulse_q[3];
  assign CalibrationL1A            = pulse_q[4];
  assign ReSync                    = pulse_q[5];
  assign bx_count                  = bx_q;
  assign orbit_count               = orbit_q;
  assign orbit_err                 = orbit_err_q;

endmodule

// File: tb/tb_hgcal_fc_aligned_decoder.sv
// Bench for hgcal_fc_aligned_decoder: directed fast-command streams, a word-level reference
// model stepped per bit, a per-cycle compare process and literal checks of key events.
`timescale 1ns/1ps
module tb_hgcal_fc_aligned_decoder;

  localparam int unsigned ORBIT_LEN  = 3564;
  localparam int unsigned LOCK_GOOD  = 16;
  localparam int unsigned UNLOCK_BAD = 4;
  localparam logic [7:0] IDLE   = 8'hAC;
  localparam logic [7:0] L1A    = 8'h4B;
  localparam logic [7:0] ORB    = 8'h2D;
  localparam logic [7:0] OCR    = 8'h33;
  localparam logic [7:0] CALREQ = 8'h55;
  localparam logic [7:0] CALL1A = 8'h66;
  localparam logic [7:0] RESYNC = 8'h99;
  localparam logic [7:0] BAD    = 8'h00;

  logic        clk320 = 1'b0;
  logic        n_rstExt = 1'b1;
  logic        command_rx = 1'b0;
  logic        clk40_out, locked, orbit_err;
  logic        L1A_Full, OrbitSync, OrbitCountReset_OrbitSync;
  logic        CalibrationReq, CalibrationL1A, ReSync;
  logic [11:0] bx_count;
  logic [15:0] orbit_count;
`ifdef FC_ERRCNT_EN
  logic [15:0] err_count;
`endif

  always #5 clk320 = ~clk320;

  hgcal_fc_aligned_decoder dut (
    .clk320                    (clk320),
    .n_rstExt                  (n_rstExt),
    .command_rx                (command_rx),
    .clk40_out                 (clk40_out),
    .locked                    (locked),
    .L1A_Full                  (L1A_Full),
    .OrbitSync                 (OrbitSync),
    .OrbitCountReset_OrbitSync (OrbitCountReset_OrbitSync),
    .CalibrationReq            (CalibrationReq),
    .CalibrationL1A            (CalibrationL1A),
    .ReSync                    (ReSync),
    .bx_count                  (bx_count),
    .orbit_count               (orbit_count),
`ifdef FC_ERRCNT_EN
    .err_count                 (err_count),
`endif
    .orbit_err                 (orbit_err)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  int edge_cnt = 0;
  int lock_edge = -1;
  int oerr_cycles = 0;
  int l1a_cycles = 0;

  // Reference model: bits left until the next word boundary, word window, link/timing state
  int         m_left;
  logic [7:0] m_hist;
  logic [7:0] m_cmd;
  bit         m_clk, m_lock, m_bxv, m_oerr;
  int         m_good, m_bad, m_bx, m_orb, m_err;

  task automatic model_reset();
    m_left = 7; m_hist = '0; m_cmd = '0;
    m_clk = 0; m_lock = 0; m_bxv = 0; m_oerr = 0;
    m_good = 0; m_bad = 0; m_bx = 0; m_orb = 0; m_err = 0;
  endtask

  function automatic bit is_cmd(input logic [7:0] w);
    return (w == L1A) || (w == ORB) || (w == OCR) || (w == CALREQ) || (w == CALL1A) ||
           (w == RESYNC);
  endfunction

  task automatic bump_err();
    if (m_err < 65535) m_err++;
  endtask

  task automatic model_step(input logic b);
    logic [7:0] w;
    bit slip;
    int nb;
    w = {m_hist[6:0], b};
    m_hist = w;
    m_clk = (m_left > 3);
    m_oerr = 0;
    slip = 0;
    if (m_left == 0) begin
      if (!m_lock) begin
        m_cmd = '0;
        if (w == IDLE) begin
          m_good++;
          if (m_good == LOCK_GOOD) begin m_lock = 1; m_bad = 0; end
        end else if (!is_cmd(w)) begin
          m_good = 0;
          slip = 1;
        end
      end else begin
        if (w == OCR) begin
          m_bx = 0; m_orb = 0; m_bxv = 1; m_err = 0;
        end else begin
          nb = m_bx + 1;
          if (nb == ORBIT_LEN) begin nb = 0; m_orb = (m_orb + 1) % 65536; end
          if (w == ORB) begin
            if (m_bxv && m_bx != ORBIT_LEN - 1) begin m_oerr = 1; bump_err(); end
            nb = 0;
            m_bxv = 1;
          end
          m_bx = nb;
        end
        if (w == IDLE || is_cmd(w)) begin
          m_bad = 0;
          m_cmd = (w == IDLE) ? 8'h00 : w;
        end else begin
          m_cmd = '0;
          m_bad++;
          bump_err();
          if (m_bad == UNLOCK_BAD) begin m_lock = 0; m_good = 0; m_bxv = 0; end
        end
      end
      m_left = slip ? 0 : 7;
    end else begin
      m_left--;
    end
  endtask

  function automatic logic [5:0] dut_pulses();
    return {ReSync, CalibrationL1A, CalibrationReq, OrbitCountReset_OrbitSync, OrbitSync,
            L1A_Full};
  endfunction

  function automatic logic [63:0] dut_vec();
`ifdef FC_ERRCNT_EN
    return 64'({clk40_out, locked, dut_pulses(), orbit_err, bx_count, orbit_count, err_count});
`else
    return 64'({clk40_out, locked, dut_pulses(), orbit_err, bx_count, orbit_count});
`endif
  endfunction

  function automatic logic [63:0] exp_vec();
    logic [5:0] p;
    p = {m_cmd == RESYNC, m_cmd == CALL1A, m_cmd == CALREQ, m_cmd == OCR, m_cmd == ORB,
         m_cmd == L1A};
`ifdef FC_ERRCNT_EN
    return 64'({m_clk, m_lock, p, m_oerr, 12'(m_bx), 16'(m_orb), 16'(m_err)});
`else
    return 64'({m_clk, m_lock, p, m_oerr, 12'(m_bx), 16'(m_orb)});
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk320) begin
    if (check_en) check("cycle", dut_vec(), exp_vec());
  end

  task automatic send_bit(input logic b);
    command_rx = b;
    @(posedge clk320);
    model_step(b);
    @(negedge clk320);
    if (locked === 1'b1 && lock_edge < 0) lock_edge = edge_cnt;
    if (orbit_err === 1'b1) oerr_cycles++;
    if (L1A_Full === 1'b1) l1a_cycles++;
    edge_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    #1 n_rstExt = 1'b0;
    model_reset();
    #1 check("reset_zero", dut_vec(), 64'd0);
    repeat (2) @(negedge clk320);
    #1 n_rstExt = 1'b1;
    edge_cnt = 0;
    lock_edge = -1;
  endtask

  // Three junk bits put the first aligned IDLE at edges 3..10: three slips, lock on edge 130
  task automatic relock();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    repeat (16) send_byte(IDLE);
    check("lock_edge", 64'(lock_edge), 64'd130);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    check_en = 1'b1;

    relock();

    send_byte(IDLE);
    l1a_cycles = 0;
    send_byte(L1A);
    check("l1a_start", 64'(dut_pulses()), 64'h01);
    send_byte(IDLE);
    check("l1a_width", 64'(l1a_cycles), 64'd8);

    send_byte(OCR);
    check("ocr_bx", 64'(bx_count), 64'd0);
    check("ocr_orbit", 64'(orbit_count), 64'd0);
    repeat (ORBIT_LEN - 1) send_byte(IDLE);
    check("bx_at_end", 64'(bx_count), 64'd3563);
    oerr_cycles = 0;
    send_byte(ORB);
    check("sync_bx", 64'(bx_count), 64'd0);
    check("sync_orbit", 64'(orbit_count), 64'd1);
    check("sync_no_err", 64'(oerr_cycles), 64'd0);

    repeat (100) send_byte(IDLE);
    check("bx_100", 64'(bx_count), 64'd100);
    send_byte(ORB);
    check("mis_err", 64'(orbit_err), 64'd1);
    check("mis_bx", 64'(bx_count), 64'd0);
    send_byte(IDLE);
    check("mis_err_width", 64'(oerr_cycles), 64'd1);

    send_byte(OCR);
    repeat (3) send_byte(BAD);
    send_byte(IDLE);
    check("hyst_hold", 64'(locked), 64'd1);
`ifdef FC_ERRCNT_EN
    check("err_3", 64'(err_count), 64'd3);
`endif
    repeat (3) send_byte(BAD);
    check("still_locked", 64'(locked), 64'd1);
    send_byte(BAD);
    check("unlocked", 64'(locked), 64'd0);
    check("no_pulse", 64'(dut_pulses()), 64'd0);
`ifdef FC_ERRCNT_EN
    check("err_7", 64'(err_count), 64'd7);
`endif
    repeat (20) send_byte(IDLE);
    check("relock_aligned", 64'(locked), 64'd1);

    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    do_reset();
    relock();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
